// File: rtl/io_port_bank_pkg.sv
// Shared constants for the parametrised I/O port bank: port limit, IOC clear
// polarity and the TRIS reset pattern.
`ifndef IO_PORT_BANK_PKG_SV
`define IO_PORT_BANK_PKG_SV

// All-ones TRIS pattern applied at reset: every pin starts as an input.
`define IO_PORT_TRIS_RESET '1

package io_port_bank_pkg;

   localparam int PORT_BANK_MAX_PORTS = 4;

   // IOC flags are write-1-to-clear: a 1 in wr_data clears that flag bit.
   localparam bit IOC_CLR_ON_ONE = 1'b1;

endpackage

`endif

// File: rtl/io_port_bit_sync.sv
// Multi-stage input synchroniser for one port's pad bits; q is the last stage.
module io_port_bit_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   // NOTE: non-blocking assignment lets every stage sample its predecessor's
   // old value, so the chain really is STAGES flops deep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// Parametrised PIC-style I/O port bank: data latches, TRIS direction,
// synchronised pad inputs and sticky interrupt-on-change flags.
module io_port_bank
   import io_port_bank_pkg::*;
#(
   parameter int NUM_PORTS   = 3,
   parameter int DATA_W      = 8,
   parameter int SEL_W       = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tris_we,
   input  logic                        port_we,
   input  logic                        ioc_we,
   input  logic [SEL_W-1:0]            wr_sel,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic                        ioc_clr,
   input  logic [SEL_W-1:0]            rd_sel,
   output logic [DATA_W-1:0]           rd_data,
   output logic [DATA_W-1:0]           rd_flags,
   input  logic [NUM_PORTS*DATA_W-1:0] pad_in,
   output logic [NUM_PORTS*DATA_W-1:0] pad_out,
   output logic [NUM_PORTS*DATA_W-1:0] pad_oe,
   output logic                        irq
);

   localparam int ARM_MAX = SYNC_STAGES + 1;

   if (NUM_PORTS > PORT_BANK_MAX_PORTS) begin : g_bad_ports
      $error("io_port_bank: NUM_PORTS exceeds PORT_BANK_MAX_PORTS");
   end

   logic [NUM_PORTS-1:0][DATA_W-1:0] syncBus, trisBus, latchBus, maskBus, flagBus;
   logic [DATA_W-1:0]                clrMask;
   logic [2:0]                       armCnt;
   logic                             armed;

   assign clrMask = IOC_CLR_ON_ONE ? wr_data : ~wr_data;
   assign armed   = (armCnt == 3'(ARM_MAX));

   // Holds change detection off until reset-time pad values have settled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         armCnt <= '0;
      else if (!armed) armCnt <= armCnt + 3'd1;
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic              hit;
      logic [DATA_W-1:0] trisQ, latchQ, maskQ, refQ, flagQ, change, clr;

      assign hit    = (wr_sel == SEL_W'(p));
      assign clr    = (ioc_clr && hit) ? clrMask : '0;
      assign change = (syncBus[p] ^ refQ) & trisQ & maskQ & {DATA_W{armed}};

      io_port_bit_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (pad_in[p*DATA_W +: DATA_W]),
         .q   (syncBus[p])
      );

      // NOTE: every per-port register is reset, so no direction, latch or
      // pending flag survives an rst pulse.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            trisQ  <= `IO_PORT_TRIS_RESET;
            latchQ <= '0;
            maskQ  <= '0;
            refQ   <= '0;
            flagQ  <= '0;
         end else begin
            if (tris_we && hit) trisQ  <= wr_data;
            if (port_we && hit) latchQ <= wr_data;
            if (ioc_we  && hit) maskQ  <= wr_data;
            refQ  <= syncBus[p];
            flagQ <= (flagQ & ~clr) | change;  // set wins over clear
         end
      end

      assign trisBus[p]  = trisQ;
      assign latchBus[p] = latchQ;
      assign maskBus[p]  = maskQ;
      assign flagBus[p]  = flagQ;
   end

   // NOTE: outputs take defaults first so out-of-range selects infer no latch.
   always_comb begin
      rd_data  = '0;
      rd_flags = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (int'(rd_sel) == p) begin
            rd_data  = (trisBus[p] & syncBus[p]) | (~trisBus[p] & latchBus[p]);
            rd_flags = flagBus[p];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq <= 1'b0;
      else     irq <= |(flagBus & maskBus);
   end

   assign pad_out = latchBus;
   assign pad_oe  = ~trisBus;

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised successor to the fixed three-port PIC16C5x I/O logic.
- Holds, per port, a data output latch and a TRIS direction register, both written by the core.
- Adds new behaviour:
  - a multi-stage pad input synchroniser;
  - per-bit interrupt-on-change (IOC) with sticky flags;
  - a single interrupt output.
- Sits between the register file / execute-stage decode and the chip pads; replaces the hand-unrolled tristate assigns.

Parameters:
- NUM_PORTS, 3, number of ports (1..4).
- DATA_W, 8, bits per port.
- SEL_W, 2, port-select width; 2**SEL_W >= NUM_PORTS.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- tris_we  in  1  TRIS instruction strobe (one cycle, execute-state decoded)
- port_we  in  1  data-latch write strobe (register-file write to a port address)
- ioc_we  in  1  IOC mask write strobe
- wr_sel  in  SEL_W  port index for all three write strobes
- wr_data  in  DATA_W  write data (W or ALU result)
- ioc_clr  in  1  clear the IOC flags of port wr_sel at bits where wr_data=1 (write-1-to-clear)
- rd_sel  in  SEL_W  readback port index
- rd_data  out  DATA_W  readback value
- rd_flags  out  DATA_W  IOC flags of port rd_sel
- pad_in  in  NUM_PORTS*DATA_W  raw pad inputs; port p occupies [p*DATA_W +: DATA_W]
- pad_out  out  NUM_PORTS*DATA_W  output latch contents
- pad_oe  out  NUM_PORTS*DATA_W  output enable, active-high, equal to ~TRIS
- irq  out  1  OR of all (flag & mask) bits, registered

Behaviour:

Reset (rst=1, asynchronous, any time):
- TRIS = all ones, so pad_oe = 0 and every pin is an input.
- Data latches = 0, so pad_out = 0.
- IOC mask = 0, IOC flags = 0, irq = 0.
- All synchroniser stages and change-reference registers = 0.
- Arm counter = 0.
- Reset mid-operation discards pending flags; no write survives.

Writes (rising clk; all take effect next cycle):
- tris_we: TRIS[wr_sel] <= wr_data; a bit value of 1 means input.
- port_we: LATCH[wr_sel] <= wr_data, regardless of TRIS; the latch drives the pad once TRIS clears.
- ioc_we: MASK[wr_sel] <= wr_data.
- Any combination of strobes in the same cycle applies independently to the same port.
- wr_sel >= NUM_PORTS: write ignored.

Synchroniser and change detection:
- Each pad bit passes through SYNC_STAGES flops; the last stage is SYNC[p].
- REF[p] <= SYNC[p] every cycle.
- change[p] = SYNC[p] ^ REF[p] & TRIS[p] & MASK[p]. Output-mode bits never flag.
- Latency: a pad edge sets its flag SYNC_STAGES+1 cycles after it is presented; irq follows one cycle later.
- Arm counter:
  - After reset it counts 0 .. SYNC_STAGES+1 and saturates.
  - Change detection is suppressed until saturation, so reset-time pad values raise no flags.
- Flags are sticky: FLAG <= (FLAG & ~clrmask) | change.
- Set and clear on the same bit in the same cycle: set wins.
- A mask write has no retroactive effect on flags already set; irq uses the current mask.

Readback (combinational):
- rd_data per bit = TRIS ? SYNC : LATCH.
- rd_flags = FLAG[rd_sel].
- rd_sel >= NUM_PORTS: both read 0.

Outputs:
- pad_out = LATCH; pad_oe = ~TRIS.
- The chip top forms the tristate as pad_oe ? pad_out : 'z.

Decomposition:
- Shared define/package:
  - PORT_BANK_MAX_PORTS = 4;
  - the IOC flag write-1-to-clear convention;
  - default TRIS reset value as an all-ones constant macro.
- One sub-module, io_port_bit_sync: a SYNC_STAGES-deep flop chain with async active-high reset, instantiated per port with width DATA_W.
- The rest of the logic is a generate loop over ports in io_port_bank.

Test Plan:
- Reset check: assert rst mid-run after TRIS=0x00 and LATCH=0xA5 were written -> immediately pad_oe=0, pad_out=0, irq=0, rd_flags=0.
- Direction/readback:
  - Stimulus: tris_we with port 1 = 0x0F, then port_we with port 1 = 0x3C, with pad_in port 1 = 0xC3.
  - Required: next cycle pad_oe[15:8]=0xF0, pad_out[15:8]=0x3C; after SYNC_STAGES cycles rd_data(rd_sel=1)=0x33.
- IOC edge:
  - Stimulus: MASK port 0 = 0x01, TRIS port 0 = 0xFF, pad_in bit0 toggles 0->1 at cycle T.
  - Required: rd_flags bit0=1 at T+SYNC_STAGES+1 and irq=1 at T+SYNC_STAGES+2; ioc_clr with wr_data=0x01 clears both on the following cycles.
- Masking:
  - Stimulus: toggle an output-mode bit (TRIS=0), and separately an unmasked input bit.
  - Required: no flag and irq stays 0; pads held at non-zero values through reset release raise no flag during arming.
- Simultaneous set/clear: ioc_clr on bit0 in the same cycle its change is detected -> flag stays 1.
- Out-of-range index (NUM_PORTS=3): write to wr_sel=3 -> no state change; rd_sel=3 gives rd_data=0 and rd_flags=0.
